// File: rtl/surf4_pps_gen_pkg.sv
// Shared encodings for the SURF4 PPS source-select path; the register block
// imports the same mode encodings.
package surf4_pps_gen_pkg;

  typedef enum logic [1:0] {
    PPS_SEL_EXT  = 2'b00,
    PPS_SEL_INT  = 2'b01,
    PPS_SEL_AUTO = 2'b10,
    PPS_SEL_OFF  = 2'b11
  } pps_sel_e;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_EXT  = 2'd1,
    ST_HOLD = 2'd2
  } pps_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/surf4_pps_gen_edge_sync.sv
// External PPS front end: 2-flop synchronizer, rising-edge detect and a
// holdoff window that masks bounce/glitches after each accepted edge.
module surf4_pps_edge_sync #(
  parameter int HOLDOFF = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_pps,
  output logic o_ext_edge
);

  localparam int HW = $clog2(HOLDOFF + 1);

  logic [1:0]    r_sync;
  logic          r_prev;
  logic [HW-1:0] r_holdoff;
  logic          w_rise;

  assign w_rise     = r_sync[1] & ~r_prev;
  assign o_ext_edge = w_rise && (r_holdoff == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_holdoff <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pps};
      r_prev <= r_sync[1];
      if (o_ext_edge)
        r_holdoff <= HW'(HOLDOFF);
      else if (r_holdoff != '0)
        r_holdoff <= r_holdoff - 1'b1;
    end
  end

endmodule

// File: rtl/surf4_pps_gen.sv
// PPS source selection: qualifies the external pin, runs an internal
// one-second generator and muxes them with holdover into a 1-cycle pps_o.
module surf4_pps_gen
  import surf4_pps_gen_pkg::*;
#(
  parameter int INT_PERIOD = 100000000,
  parameter int TOL        = 1000,
  parameter int HOLDOFF    = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PPS,
  input  logic [1:0]  sel_i,
  input  logic        soft_pps_i,
  output logic        pps_o,
  output logic        ext_valid_o,
  output logic        src_o,
  output logic [31:0] period_o,
  output logic [31:0] pps_count_o,
  output logic        missed_o
);

  localparam int          CW      = $clog2(INT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(INT_PERIOD - 1);
  localparam logic [31:0] WIN_LO  = 32'(INT_PERIOD - TOL);
  localparam logic [31:0] WIN_HI  = 32'(INT_PERIOD + TOL);

  pps_sel_e   w_sel;
  pps_state_e r_state, w_state_nxt;
  logic          w_ext_edge, w_int_tick, w_in_win, w_lost;
  logic          r_good, w_good_nxt;
  logic          w_pulse, w_src;
  logic          r_pps, r_src, r_missed;
  logic [31:0]   r_since, r_period, r_count;
  logic [CW-1:0] r_cnt;

  assign w_sel = pps_sel_e'(sel_i);

  surf4_pps_edge_sync #(.HOLDOFF(HOLDOFF)) u_edge (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_pps      (PPS),
    .o_ext_edge (w_ext_edge)
  );

  // r_since holds the period that would be captured by an edge this cycle
  assign w_in_win   = (r_since >= WIN_LO) && (r_since <= WIN_HI);
  assign w_int_tick = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_lost      = 1'b0;
    case (r_state)
      ST_EXT: begin
        if ((w_ext_edge && !w_in_win) || (r_since > WIN_HI)) begin
          w_state_nxt = ST_HOLD;
          w_good_nxt  = 1'b0;
          w_lost      = 1'b1;
        end
      end
      ST_ACQ, ST_HOLD: begin
        if (w_ext_edge) begin
          if (!w_in_win) begin
            w_good_nxt = 1'b0;
          end else if (r_good) begin
            w_state_nxt = ST_EXT;
            w_good_nxt  = 1'b0;
          end else begin
            w_good_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_ACQ;
    endcase
  end

  always_comb begin
    w_pulse = 1'b0;
    w_src   = r_src;
    case (w_sel)
      PPS_SEL_EXT: begin
        w_pulse = w_ext_edge;
        w_src   = 1'b0;
      end
      PPS_SEL_INT: begin
        w_pulse = w_int_tick;
        w_src   = 1'b1;
      end
      PPS_SEL_AUTO: begin
        if (r_state == ST_EXT) begin
          w_pulse = w_ext_edge;
          w_src   = 1'b0;
        end else begin
          w_pulse = w_int_tick;
          w_src   = 1'b1;
        end
      end
      default: ;
    endcase
    // soft request ORs in so coincident sources still give one pulse
    w_pulse = w_pulse | soft_pps_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_ACQ;
      r_good   <= 1'b0;
      r_since  <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_pps    <= 1'b0;
      r_src    <= 1'b0;
      r_missed <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_pps    <= w_pulse;
      r_src    <= w_src;
      r_missed <= w_lost;
      if (w_pulse)
        r_count <= r_count + 32'd1;
      // clear to 1 so r_since equals the full period on the next edge cycle
      if (w_ext_edge) begin
        r_period <= r_since;
        r_since  <= 32'd1;
      end else begin
        r_since  <= sat_inc(r_since);
      end
      if (w_sel == PPS_SEL_AUTO && w_ext_edge && r_state != ST_ACQ)
        r_cnt <= '0;
      else if (w_int_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pps_o       = r_pps;
  assign ext_valid_o = (r_state == ST_EXT);
  assign src_o       = r_src;
  assign period_o    = r_period;
  assign pps_count_o = r_count;
  assign missed_o    = r_missed;

endmodule

// File: tb/tb_surf4_pps_gen.sv
// Directed bench for surf4_pps_gen with INT_PERIOD=100, TOL=4, HOLDOFF=10.
// k counts falling edges since the last reset release; times below are in k.
module tb_surf4_pps_gen;

  logic        clk = 1'b0;
  logic        rst_i, pps_in, soft_pps_i;
  logic [1:0]  sel_i;
  logic        pps_o, ext_valid_o, src_o, missed_o;
  logic [31:0] period_o, pps_count_o;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  always #5 clk = ~clk;

  surf4_pps_gen #(.INT_PERIOD(100), .TOL(4), .HOLDOFF(10)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .PPS         (pps_in),
    .sel_i       (sel_i),
    .soft_pps_i  (soft_pps_i),
    .pps_o       (pps_o),
    .ext_valid_o (ext_valid_o),
    .src_o       (src_o),
    .period_o    (period_o),
    .pps_count_o (pps_count_o),
    .missed_o    (missed_o)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic rise(input int h);
    pps_in = 1'b1;
    cyc(h);
    pps_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; pps_in = 1'b0; soft_pps_i = 1'b0; sel_i = 2'b10;
    cyc(3);
    n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL rst_pps: got %b want 0", pps_o); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ext_valid_o); end
    n_chk++; if (src_o !== 1'b0) begin n_fail++; $display("FAIL rst_src: got %b want 0", src_o); end
    n_chk++; if (period_o !== 32'd0) begin n_fail++; $display("FAIL rst_period: got %0d want 0", period_o); end
    n_chk++; if (pps_count_o !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", pps_count_o); end
    n_chk++; if (missed_o !== 1'b0) begin n_fail++; $display("FAIL rst_missed: got %b want 0", missed_o); end
  endtask

  // Auto mode: first edge at k=33 carries a 32-cycle period, lock on the 3rd edge
  task automatic test_auto_lock;
    rst_i = 1'b0; k = 0;
    cyc(30); rise(3);
    n_chk++; if (period_o !== 32'd32) begin n_fail++; $display("FAIL lock_e1_period: got %0d want 32", period_o); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_e1_valid: got %b want 0", ext_valid_o); end
    cyc(97); rise(3);
    n_chk++; if (period_o !== 32'd100) begin n_fail++; $display("FAIL lock_e2_period: got %0d want 100", period_o); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_e2_valid: got %b want 0", ext_valid_o); end
    cyc(97); rise(3);
    n_chk++; if (ext_valid_o !== 1'b1) begin n_fail++; $display("FAIL lock_e3_valid: got %b want 1", ext_valid_o); end
    n_chk++; if (pps_count_o !== 32'd2) begin n_fail++; $display("FAIL lock_e3_count: got %0d want 2", pps_count_o); end
    cyc(97); rise(3);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL lock_e4_pps: got %b want 1 k=%0d", pps_o, k); end
    n_chk++; if (src_o !== 1'b0) begin n_fail++; $display("FAIL lock_e4_src: got %b want 0", src_o); end
    n_chk++; if (pps_count_o !== 32'd3) begin n_fail++; $display("FAIL lock_e4_count: got %0d want 3", pps_count_o); end
    cyc(1);
    n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL lock_width: got %b want 0", pps_o); end
    cyc(96); rise(3);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL lock_e5_pps: got %b want 1 k=%0d", pps_o, k); end
    n_chk++; if (period_o !== 32'd100) begin n_fail++; $display("FAIL lock_e5_period: got %0d want 100", period_o); end
    n_chk++; if (pps_count_o !== 32'd4) begin n_fail++; $display("FAIL lock_e5_count: got %0d want 4", pps_count_o); end
  endtask

  // Last edge accepted at k=433; since-edge hits 105 in the cycle before k=538
  task automatic test_holdover;
    cyc(100);
    n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL hold_no_tick_in_ext: got %b want 0", pps_o); end
    cyc(4);
    n_chk++; if (missed_o !== 1'b0) begin n_fail++; $display("FAIL hold_missed_early: got %b want 0", missed_o); end
    cyc(1);
    n_chk++; if (missed_o !== 1'b1) begin n_fail++; $display("FAIL hold_missed: got %b want 1 k=%0d", missed_o, k); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b want 0", ext_valid_o); end
    cyc(1);
    n_chk++; if (missed_o !== 1'b0) begin n_fail++; $display("FAIL hold_missed_width: got %b want 0", missed_o); end
    n_chk++; if (src_o !== 1'b1) begin n_fail++; $display("FAIL hold_src: got %b want 1", src_o); end
    cyc(93);
    n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL hold_pre_tick: got %b want 0", pps_o); end
    cyc(1);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL hold_tick1: got %b want 1 k=%0d", pps_o, k); end
    n_chk++; if (pps_count_o !== 32'd5) begin n_fail++; $display("FAIL hold_count1: got %0d want 5", pps_count_o); end
    cyc(100);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL hold_tick2: got %b want 1 k=%0d", pps_o, k); end
    n_chk++; if (pps_count_o !== 32'd6) begin n_fail++; $display("FAIL hold_count2: got %0d want 6", pps_count_o); end
  endtask

  // External mode: glitch inside holdoff ignored, then relock HOLD -> EXT
  task automatic test_glitch;
    sel_i = 2'b00;
    cyc(27); rise(2); cyc(1);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL glitch_first_pps: got %b want 1 k=%0d", pps_o, k); end
    n_chk++; if (period_o !== 32'd330) begin n_fail++; $display("FAIL glitch_first_period: got %0d want 330", period_o); end
    n_chk++; if (pps_count_o !== 32'd7) begin n_fail++; $display("FAIL glitch_count: got %0d want 7", pps_count_o); end
    cyc(2); rise(2);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL glitch_ignored: got %b want 0 k=%0d", pps_o, k); end
    end
    n_chk++; if (period_o !== 32'd330) begin n_fail++; $display("FAIL glitch_period_kept: got %0d want 330", period_o); end
    cyc(87); rise(3);
    n_chk++; if (period_o !== 32'd100) begin n_fail++; $display("FAIL relock_e1_period: got %0d want 100", period_o); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL relock_e1_valid: got %b want 0", ext_valid_o); end
    cyc(97); rise(3);
    n_chk++; if (ext_valid_o !== 1'b1) begin n_fail++; $display("FAIL relock_e2_valid: got %b want 1", ext_valid_o); end
    n_chk++; if (pps_count_o !== 32'd9) begin n_fail++; $display("FAIL relock_count: got %0d want 9", pps_count_o); end
  endtask

  task automatic test_out_of_window;
    cyc(87); rise(3);
    n_chk++; if (period_o !== 32'd90) begin n_fail++; $display("FAIL oow_period: got %0d want 90", period_o); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL oow_valid: got %b want 0", ext_valid_o); end
    n_chk++; if (missed_o !== 1'b1) begin n_fail++; $display("FAIL oow_missed: got %b want 1", missed_o); end
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL oow_pps: got %b want 1", pps_o); end
    n_chk++; if (pps_count_o !== 32'd10) begin n_fail++; $display("FAIL oow_count: got %0d want 10", pps_count_o); end
    cyc(1);
    n_chk++; if (missed_o !== 1'b0) begin n_fail++; $display("FAIL oow_missed_width: got %b want 0", missed_o); end
  endtask

  // Internal phase unchanged since the k=433 realign: ticks at 1133/1233/1333
  task automatic test_internal;
    logic exp_p;
    sel_i = 2'b01;
    for (int i = 0; i < 300; i++) begin
      pps_in = ((i % 23) < 4);
      cyc(1);
      exp_p = (k == 1133) || (k == 1233) || (k == 1333);
      n_chk++; if (pps_o !== exp_p) begin n_fail++; $display("FAIL int_pps: got %b want %b k=%0d", pps_o, exp_p, k); end
    end
    pps_in = 1'b0;
    n_chk++; if (pps_count_o !== 32'd13) begin n_fail++; $display("FAIL int_count: got %0d want 13", pps_count_o); end
  endtask

  task automatic test_coincidence;
    sel_i = 2'b11;
    for (int i = 0; i < 119; i++) begin
      pps_in = ((i % 31) < 3);
      cyc(1);
      n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL off_quiet: got %b want 0 k=%0d", pps_o, k); end
    end
    pps_in = 1'b0;
    soft_pps_i = 1'b1; cyc(1);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL off_soft_pps: got %b want 1", pps_o); end
    n_chk++; if (pps_count_o !== 32'd14) begin n_fail++; $display("FAIL off_soft_count: got %0d want 14", pps_count_o); end
    soft_pps_i = 1'b0; cyc(1);
    n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL off_soft_width: got %b want 0", pps_o); end
    sel_i = 2'b01;
    cyc(57);
    soft_pps_i = 1'b1; cyc(1);
    n_chk++; if (pps_o !== 1'b1) begin n_fail++; $display("FAIL coin_pps: got %b want 1 k=%0d", pps_o, k); end
    n_chk++; if (pps_count_o !== 32'd15) begin n_fail++; $display("FAIL coin_count: got %0d want 15", pps_count_o); end
    soft_pps_i = 1'b0; cyc(1);
    n_chk++; if (pps_o !== 1'b0) begin n_fail++; $display("FAIL coin_width: got %b want 0", pps_o); end
    n_chk++; if (pps_count_o !== 32'd15) begin n_fail++; $display("FAIL coin_count_once: got %0d want 15", pps_count_o); end
  endtask

  task automatic test_reset_mid;
    logic exp_p;
    cyc(20);
    #2 rst_i = 1'b1;
    #1;
    n_chk++; if (pps_count_o !== 32'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", pps_count_o); end
    n_chk++; if (period_o !== 32'd0) begin n_fail++; $display("FAIL rmid_period: got %0d want 0", period_o); end
    n_chk++; if (src_o !== 1'b0) begin n_fail++; $display("FAIL rmid_src: got %b want 0", src_o); end
    n_chk++; if (ext_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", ext_valid_o); end
    n_chk++; if (pps_o !== 1'b0 || missed_o !== 1'b0) begin n_fail++; $display("FAIL rmid_pulses: got %b%b want 00", pps_o, missed_o); end
    cyc(3);
    rst_i = 1'b0; k = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      exp_p = (k == 100);
      n_chk++; if (pps_o !== exp_p) begin n_fail++; $display("FAIL rmid_first_tick: got %b want %b k=%0d", pps_o, exp_p, k); end
    end
    n_chk++; if (pps_count_o !== 32'd1) begin n_fail++; $display("FAIL rmid_tick_count: got %0d want 1", pps_count_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_auto_lock;
    test_holdover;
    test_glitch;
    test_out_of_window;
    test_internal;
    test_coincidence;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
